// File: rtl/pea_fifo_v2_if.sv
// Handshake and status bundle for pea_fifo_v2.
// The host side uses the master modport and the FIFO uses the slave modport.
interface pea_fifo_v2_if #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic             wr_en;
    logic             rd_en;
    logic             flush;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    peek_offset;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] peek_out;
    logic             peek_valid;
    logic [CW-1:0]    population;
    logic [CW-1:0]    free_space;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, rd_en, flush, din, peek_offset,
        input  dout, peek_out, peek_valid, population, free_space,
               full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, flush, din, peek_offset,
        output dout, peek_out, peek_valid, population, free_space,
               full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/pea_fifo_v2.sv
// First-word-fall-through FIFO with peek port, watermark flags and sticky
// overflow/underflow errors. DEPTH must be a power of two (pointers roll over
// naturally). Every status output is decoded from the occupancy counter, so a
// completely full buffer is distinguishable from an empty one.
module pea_fifo_v2 #(
    parameter int DEPTH    = 1024,
    parameter int WIDTH    = 16,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input logic            clk,
    input logic            rst,
    pea_fifo_v2_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_rdAccept;
    logic             w_wrAccept;
    logic             w_wrReject;
    logic             w_rdReject;
    logic [AW-1:0]    w_peekAddr;
    logic             w_peekValid;

    // Decide which requests are honoured; a read frees a slot for a write when full.
    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == DEPTH_C);
        w_rdAccept = bus.rd_en && !w_empty;
        w_wrAccept = bus.wr_en && (!w_full || w_rdAccept);
        w_wrReject = bus.wr_en && !w_wrAccept;
        w_rdReject = bus.rd_en && !w_rdAccept;
    end

    // Pointers, occupancy and sticky error flags; flush overrides any request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_wrAccept, w_rdAccept})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_wrReject) begin
                r_overflow <= 1'b1;
            end
            if (w_rdReject) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage array is deliberately not reset; the counter makes stale words invisible.
    always_ff @(posedge clk) begin
        if (w_wrAccept && !bus.flush) begin
            r_mem[r_wrPtr] <= bus.din;
        end
    end

    // Lookahead address and validity relative to the current head.
    always_comb begin
        w_peekAddr  = r_rdPtr + bus.peek_offset;
        w_peekValid = ({1'b0, bus.peek_offset} < r_count);
    end

    assign bus.dout         = w_empty ? '0 : r_mem[r_rdPtr];
    assign bus.peek_out     = w_peekValid ? r_mem[w_peekAddr] : '0;
    assign bus.peek_valid   = w_peekValid;
    assign bus.population   = r_count;
    assign bus.free_space   = DEPTH_C - r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= AF_C);
    assign bus.almost_empty = (r_count <= AE_C);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_pea_fifo_v2.sv
// Directed testbench for pea_fifo_v2 (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
// A table of hand-computed vectors covers fill/drain, full and empty
// simultaneous access, wrap and peek; short hand sequences cover flush
// with requests pending and an asynchronous reset between clock edges.
module tb_pea_fifo_v2;
    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic        fl;
        logic [15:0] din;
        logic [2:0]  off;
        logic [15:0] expDout;
        logic [15:0] expPeek;
        logic [3:0]  expPop;
        logic        expOvf;
        logic        expUnf;
        logic        expPv;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    pea_fifo_v2_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    pea_fifo_v2 #(
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .AF_LEVEL(6),
        .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expFlags(logic [3:0] pop, logic ovf, logic unf, logic pv);
        return {17'b0, pop, 4'(4'd8 - pop), pop == 4'd8, pop == 4'd0,
                pop >= 4'd6, pop <= 4'd2, ovf, unf, pv};
    endfunction

    function automatic logic [31:0] actFlags();
        return {17'b0, bus.population, bus.free_space, bus.full, bus.empty,
                bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow,
                bus.peek_valid};
    endfunction

    function void addVec(string name, logic wr, logic rd, logic fl, logic [15:0] din,
                         logic [2:0] off, logic [15:0] eDout, logic [15:0] ePeek,
                         logic [3:0] ePop, logic eOvf, logic eUnf, logic ePv);
        vec_t v;
        v.name = name; v.wr = wr; v.rd = rd; v.fl = fl; v.din = din; v.off = off;
        v.expDout = eDout; v.expPeek = ePeek; v.expPop = ePop;
        v.expOvf = eOvf; v.expUnf = eUnf; v.expPv = ePv;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idleInputs();
        bus.wr_en       = 1'b0;
        bus.rd_en       = 1'b0;
        bus.flush       = 1'b0;
        bus.din         = '0;
        bus.peek_offset = '0;
    endtask

    task automatic applyStimulus(vec_t v);
        bus.wr_en       = v.wr;
        bus.rd_en       = v.rd;
        bus.flush       = v.fl;
        bus.din         = v.din;
        bus.peek_offset = v.off;
        @(posedge clk);
        #1;
        checkOutput({v.name, ".dout"}, 32'(bus.dout), 32'(v.expDout));
        checkOutput({v.name, ".peek"}, 32'(bus.peek_out), 32'(v.expPeek));
        checkOutput({v.name, ".flags"}, actFlags(), expFlags(v.expPop, v.expOvf, v.expUnf, v.expPv));
    endtask

    task automatic handVec(string name, logic wr, logic rd, logic fl, logic [15:0] din,
                           logic [15:0] eDout, logic [3:0] ePop, logic eOvf, logic eUnf);
        vec_t v;
        v.name = name; v.wr = wr; v.rd = rd; v.fl = fl; v.din = din; v.off = '0;
        v.expDout = eDout; v.expPeek = eDout; v.expPop = ePop;
        v.expOvf = eOvf; v.expUnf = eUnf; v.expPv = (ePop != 4'd0);
        applyStimulus(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idleInputs();

        // Fill 1..8, one dropped write, drain in order, flush clears overflow.
        for (int k = 1; k <= 8; k++)
            addVec("fill", 1, 0, 0, 16'(k), 0, 16'h1, 16'h1, 4'(k), 0, 0, 1);
        addVec("overflowWr", 1, 0, 0, 16'h0099, 0, 16'h1, 16'h1, 4'd8, 1, 0, 1);
        for (int j = 1; j <= 8; j++)
            addVec("drain", 0, 1, 0, 0, 0, (j < 8) ? 16'(j + 1) : 16'h0,
                   (j < 8) ? 16'(j + 1) : 16'h0, 4'(8 - j), 1, 0, (j < 8));
        addVec("flushOvf", 0, 0, 1, 0, 0, 16'h0, 16'h0, 4'd0, 0, 0, 0);

        // Full with read and write together: head popped, new word takes freed slot.
        for (int k = 1; k <= 8; k++)
            addVec("refill", 1, 0, 0, 16'(k), 0, 16'h1, 16'h1, 4'(k), 0, 0, 1);
        addVec("fullRdWr", 1, 1, 0, 16'h0009, 0, 16'h2, 16'h2, 4'd8, 0, 0, 1);
        for (int r = 1; r <= 8; r++)
            addVec("drainB", 0, 1, 0, 0, 0, (r < 8) ? 16'(r + 2) : 16'h0,
                   (r < 8) ? 16'(r + 2) : 16'h0, 4'(8 - r), 0, 0, (r < 8));

        // Empty with read and write together: write taken, read flagged.
        addVec("emptyRdWr", 1, 1, 0, 16'h00AA, 0, 16'h00AA, 16'h00AA, 4'd1, 0, 1, 1);
        addVec("flushUnf", 0, 0, 1, 0, 0, 16'h0, 16'h0, 4'd0, 0, 0, 0);

        // Wrap the pointers, then peek across the wrap point.
        for (int k = 1; k <= 6; k++)
            addVec("wrapWrA", 1, 0, 0, 16'(16'h10 + k), 0, 16'h11, 16'h11, 4'(k), 0, 0, 1);
        for (int r = 1; r <= 5; r++)
            addVec("wrapRd", 0, 1, 0, 0, 0, 16'(16'h11 + r), 16'(16'h11 + r), 4'(6 - r), 0, 0, 1);
        for (int k = 1; k <= 6; k++)
            addVec("wrapWrB", 1, 0, 0, 16'(16'h20 + k), 0, 16'h16, 16'h16, 4'(1 + k), 0, 0, 1);
        addVec("peek3", 0, 0, 0, 0, 3, 16'h16, 16'h23, 4'd7, 0, 0, 1);
        addVec("peek6", 0, 0, 0, 0, 6, 16'h16, 16'h26, 4'd7, 0, 0, 1);
        addVec("peek7", 0, 0, 0, 0, 7, 16'h16, 16'h00, 4'd7, 0, 0, 0);

        // Reset state, checked while reset is still held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.flags", actFlags(), expFlags(4'd0, 0, 0, 0));
        checkOutput("reset.dout", 32'(bus.dout), 32'h0);
        checkOutput("reset.peek", 32'(bus.peek_out), 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Queue now holds 0x16,0x21..0x26; fill to full, drop one, then flush with requests.
        handVec("toFull", 1, 0, 0, 16'h0030, 16'h16, 4'd8, 0, 0);
        handVec("dropWr", 1, 0, 0, 16'h0031, 16'h16, 4'd8, 1, 0);
        handVec("flushWithReq", 1, 1, 1, 16'h0055, 16'h0, 4'd0, 0, 0);
        handVec("postFlushA", 1, 0, 0, 16'h0040, 16'h40, 4'd1, 0, 0);
        handVec("postFlushB", 1, 0, 0, 16'h0041, 16'h40, 4'd2, 0, 0);
        idleInputs();

        // Reset between edges must clear outputs at once.
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst.flags", actFlags(), expFlags(4'd0, 0, 0, 0));
        checkOutput("asyncRst.dout", 32'(bus.dout), 32'h0);
        checkOutput("asyncRst.peek", 32'(bus.peek_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        handVec("afterRst", 1, 0, 0, 16'h0077, 16'h77, 4'd1, 0, 0);
        idleInputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
